seg7_scan: RTL and testbench

- Parametrised multiplexed N-digit 7-segment scanner.
- Successor to the fixed 4-digit, every-clock scan driver.
- Adds:
  - a programmable refresh prescaler
  - an anti-ghosting blank window between digits
  - per-digit decimal points and blanking
  - leading-zero suppression
  - 16-level PWM brightness
  - tear-free frame snapshotting
- Sits between CPU-visible display registers and the board's segment/anode pins.

---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_scan_timer.sv | 39 +++
 rtl/seg7_scan.sv | 100 ++++++++++
 tb/tb_seg7_scan.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared font table, hex decoder and segment bit positions for seg7_scan
package seg7_pkg;

    localparam int SEG_DP = 7;

    // gfedcba, bit 0 = segment a
    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return FONT[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// seg7_scan_timer: slot/digit scan counters with slot-wrap and frame-start strobes
module seg7_scan_timer #(
    parameter int DIGITS = 4,
    parameter int REFRESH_DIV = 50000,
    localparam int SW = $clog2(REFRESH_DIV),
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [SW-1:0] slot_cnt_o,
    output logic [DW-1:0] digit_o,
    output logic          slot_wrap_o,
    output logic          frame_o
);

    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [DW-1:0] digit_q, digit_d;

    always_comb begin
        slot_wrap_o = slot_cnt_q == SW'(REFRESH_DIV - 1);
        frame_o     = slot_cnt_q == '0 && digit_q == '0;
        slot_cnt_d  = slot_wrap_o ? '0 : slot_cnt_q + 1'b1;
        digit_d     = !slot_wrap_o ? digit_q : (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_cnt_q <= '0;
            digit_q    <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            digit_q    <= digit_d;
        end
    end

    assign slot_cnt_o = slot_cnt_q;
    assign digit_o    = digit_q;

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed N-digit 7-segment scanner with blank window, leading-zero
// suppression, PWM brightness and per-frame snapshot of the display registers
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYCLES = 64,
    parameter bit SEG_ACTIVE_LOW = 1,
    parameter bit SEL_ACTIVE_LOW = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*DIGITS-1:0]   i_data,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic [DIGITS-1:0]     i_blank,
    input  logic                  i_lz_en,
    input  logic [3:0]            i_bright,
    output logic [7:0]            o_seg,
    output logic [DIGITS-1:0]     o_sel,
    output logic                  o_frame
);

    localparam int SW = $clog2(REFRESH_DIV);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0] SEG_INV = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_INV = {DIGITS{SEL_ACTIVE_LOW}};

    logic [SW-1:0]       slot_cnt;
    logic [DW-1:0]       digit;
    logic                slot_wrap, snap;
    logic [4*DIGITS-1:0] shadow_data_q, cur_data;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_blank_q, cur_dp, cur_blank;
    logic [3:0]          pwm_cnt_q, nib;
    logic                upper_nz, dark, lit;
    logic [7:0]          seg_d, seg_q;
    logic [DIGITS-1:0]   sel_d, sel_q;
    logic                frame_q;

    seg7_scan_timer #(
        .DIGITS(DIGITS),
        .REFRESH_DIV(REFRESH_DIV)
    ) u_timer (
        .clk_i(i_clk),
        .rst_i(i_rst),
        .slot_cnt_o(slot_cnt),
        .digit_o(digit),
        .slot_wrap_o(slot_wrap),
        .frame_o(snap)
    );

    // On the snapshot cycle the freshly captured frame is already the one shown
    always_comb begin
        cur_data  = snap ? i_data : shadow_data_q;
        cur_dp    = snap ? i_dp : shadow_dp_q;
        cur_blank = snap ? i_blank : shadow_blank_q;
        nib       = cur_data[4*digit +: 4];
        upper_nz  = 1'b0;
        for (int j = 0; j < DIGITS; j++)
            if (j >= int'(digit) && cur_data[4*j +: 4] != 4'd0) upper_nz = 1'b1;
        dark  = cur_blank[digit] || (i_lz_en && digit != '0 && !upper_nz);
        lit   = int'(slot_cnt) >= BLANK_CYCLES && !dark && (i_bright == 4'hF || pwm_cnt_q < i_bright);
        sel_d = lit ? DIGITS'(1) << digit : '0;
        seg_d = '0;
        if (lit) begin
            seg_d[6:0]    = hex_to_seg(nib);
            seg_d[SEG_DP] = cur_dp[digit];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow_data_q  <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            pwm_cnt_q      <= '0;
            seg_q          <= SEG_INV;
            sel_q          <= SEL_INV;
            frame_q        <= 1'b0;
        end else begin
            if (snap) begin
                shadow_data_q  <= i_data;
                shadow_dp_q    <= i_dp;
                shadow_blank_q <= i_blank;
            end
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
            seg_q     <= seg_d ^ SEG_INV;
            sel_q     <= sel_d ^ SEL_INV;
            frame_q   <= snap;
        end
    end

    assign o_seg   = seg_q;
    assign o_sel   = sel_q;
    assign o_frame = frame_q;

    logic unused_wrap;
    assign unused_wrap = slot_wrap;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed checks of scan timing, suppression, snapshotting, PWM and reset
module tb_seg7_scan;

    logic        clk;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp, blank, bright;
    logic        lz;
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic        frame;

    logic [15:0] data2;
    logic [3:0]  bright2;
    logic [7:0]  seg2;
    logic [3:0]  sel2;
    logic        frame2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int st = 0;

    seg7_scan #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_dp(dp), .i_blank(blank),
        .i_lz_en(lz), .i_bright(bright), .o_seg(seg), .o_sel(sel), .o_frame(frame)
    );

    seg7_scan #(.DIGITS(4), .REFRESH_DIV(64), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) u_pwm (
        .i_clk(clk), .i_rst(rst), .i_data(data2), .i_dp(4'b0000), .i_blank(4'b0000),
        .i_lz_en(1'b0), .i_bright(bright2), .o_seg(seg2), .o_sel(sel2), .o_frame(frame2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s state=%0d: got %h expected %h", tag, st, got, exp);
        end
    endtask

    // Outputs observed after a tick reflect counter state st
    task automatic tick();
        @(posedge clk);
        #1;
        st = cyc;
        cyc++;
    endtask

    // e packs per-digit expected o_seg {d3,d2,d1,d0}; 8'hFF marks a dark digit
    task automatic chk_cycle(input logic [31:0] e);
        int s, d;
        logic [7:0] ed;
        logic [3:0] es;
        s  = st % 8;
        d  = (st / 8) % 4;
        ed = e[8*d +: 8];
        es = (s < 2 || ed == 8'hFF) ? 4'hF : ~(4'b0001 << d);
        chk("sel", {4'h0, sel}, {4'h0, es});
        chk("seg", seg, (s < 2) ? 8'hFF : ed);
        chk("frame", {7'd0, frame}, {7'd0, (st % 32) == 0});
    endtask

    task automatic frame_check(input logic [31:0] e, input int chg_at, input logic [15:0] chg_data);
        for (int i = 0; i < 32; i++) begin
            tick();
            chk_cycle(e);
            if (i == chg_at) data = chg_data;
        end
    endtask

    task automatic align();
        while (cyc % 32 != 0) tick();
    endtask

    initial begin
        rst = 1'b1;
        data = 16'h12AB;
        dp = 4'b0000;
        blank = 4'b0000;
        lz = 1'b0;
        bright = 4'hF;
        data2 = 16'h8888;
        bright2 = 4'd4;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_seg", seg, 8'hFF);
            chk("rst_sel", {4'h0, sel}, 8'h0F);
            chk("rst_frame", {7'd0, frame}, 8'd0);
        end
        rst = 1'b0;
        cyc = 0;
        frame_check(32'hF9A48883, -1, 16'h0);
        frame_check(32'hF9A48883, -1, 16'h0);
        data = 16'h0050;
        lz = 1'b1;
        dp = 4'b0010;
        align();
        frame_check(32'hFFFF12C0, -1, 16'h0);
        data = 16'h0000;
        align();
        frame_check(32'hFFFFFFC0, -1, 16'h0);
        blank = 4'b0001;
        align();
        frame_check(32'hFFFFFFFF, -1, 16'h0);
        blank = 4'b0000;
        lz = 1'b0;
        dp = 4'b0000;
        data = 16'h1111;
        align();
        frame_check(32'hF9F9F9F9, -1, 16'h0);
        frame_check(32'hF9F9F9F9, 18, 16'h2222);
        frame_check(32'hA4A4A4A4, -1, 16'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_cycle(32'hA4A4A4A4);
        end
        rst = 1'b1;
        tick();
        chk("midrst_sel", {4'h0, sel}, 8'h0F);
        chk("midrst_seg", seg, 8'hFF);
        chk("midrst_frame", {7'd0, frame}, 8'd0);
        rst = 1'b0;
        cyc = 0;
        frame_check(32'hA4A4A4A4, -1, 16'h0);
        for (int w = 0; w < 4; w++) begin
            int n;
            n = 0;
            for (int i = 0; i < 16; i++) begin
                tick();
                if (sel2 !== 4'hF) begin
                    n++;
                    chk("pwm_seg", seg2, 8'h80);
                end
            end
            chk("pwm_count", 8'(n), 8'd4);
        end
        bright2 = 4'd0;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("pwm_dark_sel", {4'h0, sel2}, 8'h0F);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
